// File: rtl/rca_result_buffer.sv
// Result FIFO behind a 4-bit ripple-carry adder; stores sum bits plus Z/N/C/V flags.
// Optional sticky overflow flag: define RESULT_STICKY_OVF_EN.
module rca_result_buffer #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic S0,
  input  logic S1,
  input  logic S2,
  input  logic S3,
  input  logic C3,
  input  logic Cout,
  input  logic in_valid,
  output logic in_ready,
  output logic R0,
  output logic R1,
  output logic R2,
  output logic R3,
  output logic Z,
  output logic N,
  output logic C,
  output logic V,
  output logic out_valid,
  input  logic out_ready
`ifdef RESULT_STICKY_OVF_EN
  ,
  output logic OVF_STICKY,
  input  logic CLR_STICKY
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0] r;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          din;
  entry_t          head;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  assign din.r = {S3, S2, S1, S0};
  assign din.z = ~(S3 | S2 | S1 | S0);
  assign din.n = S3;
  assign din.c = Cout;
  assign din.v = C3 ^ Cout;

  // Ready depends only on stored count, so a pop never frees a slot same-cycle.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default:      count <= count;
      endcase
    end
  end

  assign head = out_valid ? mem[rptr] : '0;

  assign R0 = head.r[0];
  assign R1 = head.r[1];
  assign R2 = head.r[2];
  assign R3 = head.r[3];
  assign Z  = head.z;
  assign N  = head.n;
  assign C  = head.c;
  assign V  = head.v;

`ifdef RESULT_STICKY_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OVF_STICKY <= 1'b0;
    end else if (push && din.v) begin
      OVF_STICKY <= 1'b1;
    end else if (CLR_STICKY) begin
      OVF_STICKY <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/rca_result_buffer.md
RCA_RESULT_BUFFER -- requirements
Module: rca_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2: number of result entries held; legal values 2 or 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports S0, S1, S2, S3  input  1 each  sum bits from the upstream 4-bit ripple-carry adder, S0 = LSB.
REQ-005 SHALL have port C3  input  1  carry into bit 3 from the adder.
REQ-006 SHALL have port Cout  input  1  carry out of bit 3 from the adder.
REQ-007 SHALL have port in_valid  input  1  adder result on S0..S3/C3/Cout is valid this cycle.
REQ-008 SHALL have port in_ready  output  1  buffer accepts a result this cycle.
REQ-009 SHALL have ports R0, R1, R2, R3  output  1 each  head-entry result bits, R0 = LSB.
REQ-010 SHALL have ports Z, N, C, V  output  1 each  head-entry flags: zero, negative, carry, signed overflow.
REQ-011 SHALL have port out_valid  output  1  head entry present.
REQ-012 SHALL have port out_ready  input  1  consumer takes the head entry this cycle.

Function
REQ-013 SHALL push when in_valid && in_ready, capturing {S3..S0, Cout, C3} in one entry.
REQ-014 SHALL compute flags at push time: Z = (S3..S0 == 0), N = S3, C = Cout, V = C3 XOR Cout.
REQ-015 SHALL pop when out_valid && out_ready.
REQ-016 SHALL drive in_ready = (count < DEPTH), registered-state only, with no combinational path from out_ready.
REQ-017 SHALL drive out_valid = (count != 0), with R0..R3/Z/N/C/V showing the oldest entry.
REQ-018 SHALL have latency of exactly 1 cycle: a push into an empty buffer appears on out_valid the next cycle, with no same-cycle bypass.
REQ-019 SHALL, on simultaneous push and pop with 0 < count < DEPTH, keep count unchanged and preserve FIFO order.
REQ-020 SHALL, when full, refuse the push (in_ready = 0) even if a pop occurs in the same cycle; in_ready rises the cycle after the pop.
REQ-021 SHALL ignore pop requests when empty and push requests when full, leaving state unchanged.
REQ-022 SHALL keep read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, with count of log2(DEPTH)+1 bits.
REQ-023 SHALL drive R0..R3/Z/N/C/V as 0 whenever out_valid = 0.
REQ-024 SHALL hold the head outputs stable while out_valid = 1 and out_ready = 0.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear count, pointers, R0..R3, Z, N, C, V and out_valid to 0, and set in_ready to 1.
REQ-026 SHALL discard all stored entries on reset asserted mid-operation; no entry reappears after release.
REQ-027 SHALL accept a push on the first rising edge after rst_n goes high.

Configuration
REQ-028 SHALL, with macro RESULT_STICKY_OVF_EN defined, add port OVF_STICKY (output, 1 bit) and port CLR_STICKY (input, 1 bit).
REQ-029 SHALL, with RESULT_STICKY_OVF_EN defined, set OVF_STICKY on any push whose V = 1; CLR_STICKY clears it, set wins on a same-cycle conflict, and reset clears it to 0.
REQ-030 SHALL, without RESULT_STICKY_OVF_EN, omit both ports and all sticky logic, leaving behaviour otherwise identical.

Verification
REQ-031 SHALL cover basic flags: push S=0000, C3=0, Cout=1 -> next cycle out_valid=1, R=0000, Z=1, N=0, C=1, V=1.
REQ-032 SHALL cover fill to full with DEPTH=2: push 0011 then 0101 with out_ready=0 -> in_ready=0; third push ignored; pops return 0011 then 0101.
REQ-033 SHALL cover simultaneous push and pop at count=1: push 1000 while popping 0001 -> count stays 1, next head R=1000, N=1.
REQ-034 SHALL cover full with pop: DEPTH=2 full, out_ready=1 and in_valid=1 -> push refused this cycle, in_ready=1 next cycle.
REQ-035 SHALL cover reset mid-operation: 2 entries held, rst_n pulsed low -> out_valid=0, R=0000, in_ready=1 immediately; no old data after release.
REQ-036 SHALL cover the sticky flag with RESULT_STICKY_OVF_EN: push C3=1, Cout=0 -> OVF_STICKY=1; CLR_STICKY in same cycle as another V=1 push -> stays 1; lone CLR_STICKY -> 0.
